// File: rtl/prog_fetch.sv
// prog_fetch: instruction-supply stage feeding the multicycle processor's DIN.
// Holds a loadable program memory and a PC, and tracks processor time steps
// through Done so instruction words appear at step 0 and mvi immediates at step 1.
module prog_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic [ADDR_W-1:0] PC
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [2:0]  OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_FETCH,
    S_IMM,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              run_q;
  logic              busy_q;
  logic              mem_we_c;
  logic [DATA_W-1:0] din_c;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // Asynchronous read of the word at the current PC.
  assign rd_word = mem[pc_q];

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we_c) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Next-state, PC, halt flag and combinational DIN selection.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    din_c    = '0;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we_c = LoadEn;
        if (Start) begin
          state_d  = S_SYNC;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      S_SYNC: begin
        // Processor Done marks the end of its current step; step 0 follows.
        if (Done) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_word[8]) begin
          // Halt opcode is swallowed; the processor sees a harmless filler.
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          din_c   = rd_word;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (rd_word[8:6] == OP_MVI) ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        din_c   = rd_word;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = Done ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and status registers; Run/Busy track the state being entered.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      run_q    <= (state_d == S_FETCH) || (state_d == S_IMM) || (state_d == S_WAIT);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign DIN    = din_c;
  assign Run    = run_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;
  assign PC     = pc_q;

endmodule

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
- Instruction-supply stage that sits directly upstream of the 16-bit multicycle processor and drives its DIN input.
- Holds a small loadable program memory and a program counter (PC).
- Tracks the processor's time steps from its Done output, presenting each instruction word at step 0 and the mvi immediate word at step 1.
- Stops on a halt opcode, after which the memory can be reloaded.

Parameters:
ADDR_W  5   program memory address width; depth = 2^ADDR_W words
DATA_W  16  word width; must equal the processor DIN width

Ports:
Clock     in   1       system clock, rising edge
Resetn    in   1       asynchronous active-low reset
Start     in   1       level; begin execution from address 0 (sampled in IDLE only)
LoadEn    in   1       write enable for program memory (honoured in IDLE only)
LoadAddr  in   ADDR_W  program memory write address
LoadData  in   DATA_W  program memory write data
Done      in   1       processor Done (combinational, high in the instruction's final step)
DIN       out  DATA_W  word driven to the processor DIN
Run       out  1       high while a program is executing (FETCH/IMM/WAIT)
Busy      out  1       high in any state other than IDLE
Halted    out  1       sticky; set when a halt opcode is fetched, cleared by Start
PC        out  ADDR_W  current program counter

Behaviour:
- Opcode is DIN[8:6], matching the processor's 9-bit IR.
  - 000 mv, 001 mvi, 010 add, 011 sub.
  - 1xx is HALT: consumed by this block and never executed.
- Filler word is 16'h0000 (mv R0,R0). It is harmless, asserts Done in the processor's step 1, and keeps the processor cycling steps 0,1.
- Async reset: state=IDLE, PC=0, Halted=0, Run=0, Busy=0, DIN=0. Memory contents are not reset.
- States: IDLE, SYNC, FETCH, IMM, WAIT. All transitions occur on the rising Clock edge.
- IDLE: DIN=0, Run=0.
  - LoadEn=1 writes mem[LoadAddr]<=LoadData.
  - Start=1 -> SYNC, PC<=0, Halted<=0.
  - If LoadEn and Start are both high, the write is performed and execution starts. The new word is visible from the next cycle.
- SYNC: DIN=0, Busy=1. Done=1 -> FETCH (the next cycle is processor step 0); otherwise stay.
- FETCH (processor step 0): Run=1, word w=mem[PC].
  - If w[8]=1: DIN=0, Halted<=1, next IDLE, PC unchanged.
  - Else DIN=w, PC<=PC+1. Next IMM if w[8:6]=001, otherwise WAIT.
- IMM (processor step 1 of mvi): DIN=mem[PC], PC<=PC+1. Done=1 -> FETCH; otherwise WAIT.
- WAIT: DIN=0. Done=1 -> FETCH; otherwise stay.
  - mv: 1 WAIT cycle.
  - add/sub: 3 WAIT cycles.
- Instruction cadence: mv 2 cycles, mvi 2 cycles, add/sub 4 cycles, measured FETCH to FETCH.
- PC arithmetic is modulo 2^ADDR_W.
  - Wrap from the last address to 0 is silent.
  - An mvi at the last address takes its immediate from address 0.
- LoadEn and Start are ignored while Busy=1.
- Done seen in FETCH is ignored; the processor cannot legally be in its Done step there.
- Reset mid-program returns to IDLE immediately. Processor and block both restart at step 0/IDLE.
- DIN is combinational from the state and the memory read (asynchronous read array). No registered latency is added on DIN.

Test Plan:
- Reset, load {mvi R0; 16'h0005; mvi R1; 16'h0003; add R0,R1; 16'h01C0 halt}, Start with processor attached -> R0=8, R1=3, Halted=1, PC=5, Busy=0. FETCH-to-FETCH gaps are 2,2,4 cycles.
- Same program with sub (opcode 011) -> R0=2. DIN=16'h0003 in the IMM cycle of the second mvi.
- Fill mem[0..30] with mv R0,R0, set mem[31]=mvi R2, mem[0]=16'h1234 -> the immediate read wraps and R2=16'h1234. PC wraps to 1, executes mv words, and runs continuously until Resetn is pulsed.
- Pulse LoadEn and Start during execution -> memory unchanged, PC sequence unaffected.
- Assert Resetn=0 during the WAIT of an add -> immediately IDLE, PC=0, DIN=0, Run=0. A later Start reruns the program correctly.
- Idle processor with Done toggling every other cycle; raise Start one cycle after a Done pulse -> SYNC lasts until the next Done, then FETCH aligns to step 0.
